// File: rtl/lcd_backlight_fader.sv
// Backlight fader: ramps the PWM duty level up and down at a fixed rate toward on/off targets.
// The registered PWM output follows the brightness/counter values one clock later.
module lcd_backlight_fader #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 4,
  parameter int MAX_LEVEL = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                light_req,
  output logic                backlight_pwm,
  output logic [PWM_BITS-1:0] brightness,
  output logic                busy,
  output logic                at_target
);

  localparam int                  PS_W    = $clog2(RAMP_DIV + 1);
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX_L   = PWM_BITS'(MAX_LEVEL);
  localparam logic [PWM_BITS-1:0] FULL    = '1;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    state_d   = state_q;
    bright_d  = bright_q;
    presc_d   = presc_q;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    // Full scale forces a solid drive, since the counter can never exceed it.
    pwm_d     = (bright_q == FULL) || (pwm_cnt_q < bright_q);

    case (state_q)
      ST_OFF: begin
        bright_d = '0;
        presc_d  = '0;
        if (light_req) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!light_req) begin
          state_d = ST_RAMP_DOWN;
          presc_d = '0;
        end else if (bright_q >= MAX_L) begin
          state_d  = ST_ON;
          bright_d = MAX_L;
          presc_d  = '0;
        end else if (presc_q == PS_LAST) begin
          presc_d  = '0;
          bright_d = bright_q + 1'b1;
          if (bright_d == MAX_L) state_d = ST_ON;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_ON: begin
        bright_d = MAX_L;
        presc_d  = '0;
        if (!light_req) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (light_req) begin
          state_d = ST_RAMP_UP;
          presc_d = '0;
        end else if (bright_q == '0) begin
          state_d = ST_OFF;
          presc_d = '0;
        end else if (presc_q == PS_LAST) begin
          presc_d  = '0;
          bright_d = bright_q - 1'b1;
          if (bright_d == '0) state_d = ST_OFF;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      bright_q  <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bright_q  <= bright_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign backlight_pwm = pwm_q;
  assign brightness    = bright_q;
  assign busy          = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign at_target     = (state_q == ST_ON) || (state_q == ST_OFF);

endmodule

// File: tb/tb_lcd_backlight_fader.sv
// Directed bench for lcd_backlight_fader: default instance plus a MAX_LEVEL=64 instance for duty.
module tb_lcd_backlight_fader;

  logic       clk = 1'b0;
  logic       reset, light_req;
  logic       backlight_pwm, busy, at_target;
  logic [7:0] brightness;
  logic       reset2, light_req2;
  logic       backlight_pwm2, busy2, at_target2;
  logic [7:0] brightness2;

  int checks   = 0;
  int failures = 0;
  int ones;

  always #5 clk = ~clk;

  lcd_backlight_fader dut (
    .clk(clk), .reset(reset), .light_req(light_req),
    .backlight_pwm(backlight_pwm), .brightness(brightness),
    .busy(busy), .at_target(at_target)
  );

  lcd_backlight_fader #(.PWM_BITS(8), .RAMP_DIV(4), .MAX_LEVEL(64)) dut64 (
    .clk(clk), .reset(reset2), .light_req(light_req2),
    .backlight_pwm(backlight_pwm2), .brightness(brightness2),
    .busy(busy2), .at_target(at_target2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; light_req = 1'b1;
    reset2 = 1'b1; light_req2 = 1'b1;
    tick(2);
    chk("rst_brightness", brightness, 0);
    chk("rst_pwm", backlight_pwm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_at_target", at_target, 1);
    reset = 1'b0; reset2 = 1'b0;

    // Ramp up: entry edge, then one step every 4 clocks
    tick(1);
    chk("up_entry_busy", busy, 1);
    chk("up_entry_at_target", at_target, 0);
    tick(3);
    chk("up_before_first_step", brightness, 0);
    tick(1);
    chk("up_first_step", brightness, 1);
    tick(1015);
    chk("up_254", brightness, 254);
    chk("up_254_busy", busy, 1);
    tick(1);
    chk("up_255", brightness, 255);
    chk("up_on_at_target", at_target, 1);
    chk("up_on_busy", busy, 0);
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      ones += backlight_pwm;
    end
    chk("on_pwm_const1", ones, 300);

    // Full fade down from ON
    light_req = 1'b0;
    tick(1);
    chk("down_entry_busy", busy, 1);
    tick(1020);
    chk("down_full_zero", brightness, 0);
    chk("down_full_off", at_target, 1);

    // Ramp to 100, then reverse
    light_req = 1'b1;
    tick(401);
    chk("rev_at_100", brightness, 100);
    chk("rev_at_100_busy", busy, 1);
    light_req = 1'b0;
    tick(1);
    chk("rev_entry_busy", busy, 1);
    chk("rev_entry_keep", brightness, 100);
    tick(3);
    chk("rev_before_step", brightness, 100);
    tick(1);
    chk("rev_99", brightness, 99);
    tick(395);
    chk("rev_1", brightness, 1);
    chk("rev_1_busy", busy, 1);
    tick(1);
    chk("rev_0", brightness, 0);
    chk("rev_off_at_target", at_target, 1);
    chk("rev_off_busy", busy, 0);
    tick(2);
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      ones += backlight_pwm;
    end
    chk("off_pwm_const0", ones, 0);

    // Reset mid-ramp at brightness 37
    light_req = 1'b1;
    tick(149);
    chk("mid_37", brightness, 37);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_brightness", brightness, 0);
    chk("mid_rst_at_target", at_target, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pwm_cnt", dut.pwm_cnt_q, 0);
    tick(1);
    chk("mid_restart_busy", busy, 1);
    chk("mid_restart_zero", brightness, 0);
    tick(4);
    chk("mid_restart_1", brightness, 1);

    // Back to OFF, then a single-clock glitch
    light_req = 1'b0;
    tick(10);
    chk("pre_glitch_off", at_target, 1);
    light_req = 1'b1;
    tick(1);
    light_req = 1'b0;
    chk("glitch_busy1", busy, 1);
    tick(1);
    chk("glitch_busy2", busy, 1);
    chk("glitch_bright_mid", brightness, 0);
    tick(1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_off", at_target, 1);
    chk("glitch_bright", brightness, 0);

    // Duty on the MAX_LEVEL=64 instance, long since ON
    chk("duty_level", brightness2, 64);
    chk("duty_at_target", at_target2, 1);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      ones += backlight_pwm2;
    end
    chk("duty_64_of_256", ones, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
